// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle core. It gates architectural commit
// through pc_we, takes HALT/RUN/STEP/RESET_PC commands over a valid/ready port,
// stops on a PC breakpoint or when a step count runs out, and counts retired
// instructions.
module cpu_run_ctrl #(
    parameter int                 ADDR_W   = 32,
    parameter int                 CNT_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'hFFFF_FFFC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [CNT_W-1:0]  i_cmd_arg,
    input  logic              i_bp_en,
    input  logic [ADDR_W-1:0] i_bp_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_pc_we,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc_load_val,
    output logic              o_halted,
    output logic [1:0]        o_state,
    output logic [1:0]        o_halt_cause,
    output logic [31:0]       o_retired
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_RSTPC = 2'b11;

    localparam logic [1:0] C_RESET = 2'b00;
    localparam logic [1:0] C_HALT  = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_BRK   = 2'b11;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_skip_bp, w_skip_nxt;
    logic [1:0]         r_cause, w_cause_nxt;
    logic               r_load, w_load_nxt;
    logic [31:0]        r_retired;
    logic               w_clr_ret;
    logic               w_active;
    logic               w_bp_hit;
    logic               w_acc;
    logic               w_pc_we;

    assign w_active = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_bp_hit = w_active && i_bp_en && (i_pc == i_bp_addr) && !r_skip_bp;
    // Only an active state commits, and pc_load only fires from a halted
    // state, so the two enables can never overlap.
    assign w_pc_we  = w_active && !w_bp_hit;
    // The pc_load cycle is the only one that refuses commands, which keeps a
    // second RESET_PC from stretching the load pulse.
    assign w_acc    = i_cmd_valid && !r_load;

    assign o_cmd_ready   = !r_load;
    assign o_pc_we       = w_pc_we;
    assign o_pc_load     = r_load;
    assign o_pc_load_val = RESET_PC;
    assign o_halted      = (r_state == S_HALT) || (r_state == S_BRK);
    assign o_state       = r_state;
    assign o_halt_cause  = r_cause;
    assign o_retired     = r_retired;

    // State register and sequencing bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_HALT;
            r_cnt     <= '0;
            r_skip_bp <= 1'b0;
            r_cause   <= C_RESET;
            r_load    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_skip_bp <= w_skip_nxt;
            r_cause   <= w_cause_nxt;
            r_load    <= w_load_nxt;
        end
    end

    // Next-state: commands act only when halted; stops are ranked
    // breakpoint > step expiry > HALT command.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_skip_nxt  = r_skip_bp;
        w_cause_nxt = r_cause;
        w_load_nxt  = 1'b0;
        w_clr_ret   = 1'b0;
        if (!w_active) begin
            if (w_acc) begin
                case (i_cmd_op)
                    OP_RUN: begin
                        w_state_nxt = S_RUN;
                        w_skip_nxt  = (r_state == S_BRK);
                    end
                    OP_STEP: begin
                        w_state_nxt = S_STEP;
                        w_cnt_nxt   = (i_cmd_arg == '0) ? CNT_W'(1) : i_cmd_arg;
                        w_skip_nxt  = (r_state == S_BRK);
                    end
                    OP_RSTPC: begin
                        w_load_nxt = 1'b1;
                        w_clr_ret  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin
            w_skip_nxt = 1'b0;
            if (r_state == S_STEP && w_pc_we)
                w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_bp_hit) begin
                w_state_nxt = S_BRK;
                w_cause_nxt = C_BRK;
            end else if (r_state == S_STEP && r_cnt == CNT_W'(1)) begin
                w_state_nxt = S_HALT;
                w_cause_nxt = C_STEP;
            end else if (w_acc && i_cmd_op == OP_HALT) begin
                w_state_nxt = S_HALT;
                w_cause_nxt = C_HALT;
            end
        end
    end

    // Retired-instruction counter, saturating, cleared by RESET_PC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_retired <= '0;
        else if (w_clr_ret)
            r_retired <= '0;
        else if (w_pc_we && r_retired != 32'hFFFF_FFFF)
            r_retired <= r_retired + 32'd1;
    end

endmodule
